// File: rtl/bcd_stopwatch_ctrl.sv
// Three-digit BCD stopwatch sequencer: tick prescaler, run/pause/clear FSM and
// a count register advanced through one bcd_inc instance per prescaler tick.

module bcd_inc (
    input  logic [11:0] bcd_in,
    output logic [11:0] bcd_out,
    output logic        carry_out
);
    always_comb begin
        bcd_out   = bcd_in;
        carry_out = 1'b0;
        if (bcd_in[3:0] != 4'd9) begin
            bcd_out[3:0] = bcd_in[3:0] + 4'd1;
        end else begin
            bcd_out[3:0] = 4'd0;
            if (bcd_in[7:4] != 4'd9) begin
                bcd_out[7:4] = bcd_in[7:4] + 4'd1;
            end else begin
                bcd_out[7:4] = 4'd0;
                if (bcd_in[11:8] != 4'd9) begin
                    bcd_out[11:8] = bcd_in[11:8] + 4'd1;
                end else begin
                    bcd_out[11:8] = 4'd0;
                    carry_out     = 1'b1;
                end
            end
        end
    end
endmodule

module bcd_stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 10_000_000,
    parameter bit          WRAP     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clear,
    output logic [11:0] bcd,
    output logic        running,
    output logic        tick,
    output logic        wrap,
    output logic        done
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_nx;
    logic [PW-1:0] pre_q, pre_nx;
    logic [11:0]   bcd_nx, inc_out;
    logic          inc_carry, tick_nx, wrap_nx;

    bcd_inc u_inc (
        .bcd_in   (bcd),
        .bcd_out  (inc_out),
        .carry_out(inc_carry)
    );

    always_comb begin
        state_nx = state_q;
        pre_nx   = pre_q;
        bcd_nx   = bcd;
        tick_nx  = 1'b0;
        wrap_nx  = 1'b0;
        if (clear) begin
            state_nx = S_IDLE;
            pre_nx   = '0;
            bcd_nx   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    pre_nx = '0;
                    if (start_stop) state_nx = S_RUN;
                end
                S_RUN: begin
                    if (pre_q == PRE_LAST) begin
                        pre_nx = '0;
                        // Saturating mode: the step out of 999 is swallowed and lands in DONE.
                        if (inc_carry && !WRAP) begin
                            state_nx = S_DONE;
                        end else begin
                            bcd_nx  = inc_out;
                            tick_nx = 1'b1;
                            wrap_nx = inc_carry;
                            if (start_stop) state_nx = S_PAUSE;
                        end
                    end else begin
                        pre_nx = pre_q + PW'(1);
                        if (start_stop) state_nx = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (start_stop) state_nx = S_RUN;
                end
                default: begin
                    pre_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            bcd     <= '0;
            running <= 1'b0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_nx;
            pre_q   <= pre_nx;
            bcd     <= bcd_nx;
            running <= (state_nx == S_RUN);
            tick    <= tick_nx;
            wrap    <= wrap_nx;
            done    <= (state_nx == S_DONE);
        end
    end
endmodule
